// File: rtl/hilo_pipe.sv
// HI/LO write-request pipeline: EX/MEM and MEM/WB stages, commit into HI/LO at WB.
// Optional HILO_BYPASS_EN: hi_o/lo_o become write-through of the WB-stage request.
module hilo_pipe #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_whilo_i,
   input  logic [DATA_W-1:0] ex_hi_i,
   input  logic [DATA_W-1:0] ex_lo_i,
   input  logic [1:0]        stall_i,
   input  logic              flush_i,
   output logic              mem_whilo_o,
   output logic [DATA_W-1:0] mem_hi_o,
   output logic [DATA_W-1:0] mem_lo_o,
   output logic              wb_whilo_o,
   output logic [DATA_W-1:0] wb_hi_o,
   output logic [DATA_W-1:0] wb_lo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   typedef struct packed {
      logic              whilo;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } req_t;

   req_t              ex_req, mem_q, wb_q;
   logic [DATA_W-1:0] hi_q, lo_q;
   logic              s0, s1;

   assign ex_req = {ex_whilo_i, ex_hi_i, ex_lo_i};

   // A held WB with a moving MEM would let MEM overtake WB, so 2'b10 folds into a full hold.
   assign s1 = stall_i[1];
   assign s0 = stall_i[0] | stall_i[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         wb_q  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         if (wb_q.whilo) begin
            hi_q <= wb_q.hi;
            lo_q <= wb_q.lo;
         end
         if (flush_i) begin
            mem_q <= '0;
            wb_q  <= '0;
         end else if (!s1) begin
            wb_q  <= mem_q;
            mem_q <= s0 ? '0 : ex_req;
         end
      end
   end

   assign mem_whilo_o = mem_q.whilo;
   assign mem_hi_o    = mem_q.hi;
   assign mem_lo_o    = mem_q.lo;
   assign wb_whilo_o  = wb_q.whilo;
   assign wb_hi_o     = wb_q.hi;
   assign wb_lo_o     = wb_q.lo;

`ifdef HILO_BYPASS_EN
   assign hi_o = wb_q.whilo ? wb_q.hi : hi_q;
   assign lo_o = wb_q.whilo ? wb_q.lo : lo_q;
`else
   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif

endmodule
